// File: rtl/sram_access_arbiter.sv
// Two-port arbiter sharing one serial-SRAM encoder: port A has priority,
// port B is protected by a starvation limit, and a watchdog flags a hung encoder.
module sram_access_arbiter #(
    parameter int WORD_WIDTH    = 16,
    parameter int ADDRESS_WIDTH = 15,
    parameter int STARVE_LIMIT  = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     a_req,
    input  logic                     a_we,
    input  logic [ADDRESS_WIDTH-1:0] a_addr,
    input  logic [WORD_WIDTH-1:0]    a_wdata,
    output logic                     a_ack,
    output logic [WORD_WIDTH-1:0]    a_rdata,
    input  logic                     b_req,
    input  logic                     b_we,
    input  logic [ADDRESS_WIDTH-1:0] b_addr,
    input  logic [WORD_WIDTH-1:0]    b_wdata,
    output logic                     b_ack,
    output logic [WORD_WIDTH-1:0]    b_rdata,
    input  logic                     enc_initialized,
    input  logic                     enc_busy,
    input  logic [WORD_WIDTH-1:0]    enc_rdata,
    output logic                     enc_request,
    output logic                     enc_write_enable,
    output logic [ADDRESS_WIDTH-1:0] enc_address,
    output logic [WORD_WIDTH-1:0]    enc_wdata,
    output logic                     grant_b,
    output logic                     timeout_err
);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

    state_t              state;
    logic [STARVE_W-1:0] starve_cnt;
    logic [7:0]          wd_cnt;
    logic                a_guard;
    logic                b_guard;

    logic       a_elig;
    logic       b_elig;
    logic       pick_b;
    logic [7:0] wd_next;

    // A port that was acked last cycle sits out one arbitration round.
    always_comb begin
        a_elig  = a_req && !a_guard;
        b_elig  = b_req && !b_guard;
        pick_b  = b_elig && ((starve_cnt == STARVE_MAX) || !a_elig);
        wd_next = wd_cnt + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= S_INIT;
            starve_cnt       <= '0;
            wd_cnt           <= '0;
            a_guard          <= 1'b0;
            b_guard          <= 1'b0;
            a_ack            <= 1'b0;
            b_ack            <= 1'b0;
            a_rdata          <= '0;
            b_rdata          <= '0;
            enc_request      <= 1'b0;
            enc_write_enable <= 1'b0;
            enc_address      <= '0;
            enc_wdata        <= '0;
            grant_b          <= 1'b0;
            timeout_err      <= 1'b0;
        end else begin
            enc_request <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_guard     <= a_ack;
            b_guard     <= b_ack;

            case (state)
                S_INIT: begin
                    if (enc_initialized) state <= S_IDLE;
                end

                S_IDLE: begin
                    if (!enc_initialized) begin
                        state <= S_INIT;
                    end else if (a_elig || b_elig) begin
                        grant_b          <= pick_b;
                        enc_write_enable <= pick_b ? b_we    : a_we;
                        enc_address      <= pick_b ? b_addr  : a_addr;
                        enc_wdata        <= pick_b ? b_wdata : a_wdata;
                        enc_request      <= 1'b1;
                        if (pick_b || !b_elig)
                            starve_cnt <= '0;
                        else if (starve_cnt != STARVE_MAX)
                            starve_cnt <= starve_cnt + 1'b1;
                        state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wd_cnt <= '0;
                    state  <= S_WAIT_BUSY;
                end

                S_WAIT_BUSY: begin
                    if (enc_busy) begin
                        state <= S_WAIT_DONE;
                    end else begin
                        wd_cnt <= wd_next;
                        // Give up on the encoder: ack with the old read data.
                        if (wd_next == WD_LIMIT) begin
                            timeout_err <= 1'b1;
                            a_ack       <= !grant_b;
                            b_ack       <= grant_b;
                            state       <= S_RESP;
                        end
                    end
                end

                S_WAIT_DONE: begin
                    if (!enc_busy) begin
                        if (!enc_write_enable) begin
                            if (grant_b) b_rdata <= enc_rdata;
                            else         a_rdata <= enc_rdata;
                        end
                        a_ack <= !grant_b;
                        b_ack <= grant_b;
                        state <= S_RESP;
                    end
                end

                S_RESP: begin
                    state <= enc_initialized ? S_IDLE : S_INIT;
                end

                default: state <= S_INIT;
            endcase
        end
    end

endmodule
